// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
//
// Register-file write scoreboard for the five-stage in-order pipeline. It
// keeps a small saturating counter of in-flight writers per architectural
// GPR. The counter increments when decode issues a writer and decrements
// when writeback retires it. Decode is told to hold when a source register
// still has a pending writer (raw_stall), or when the destination counter
// is already full (issue_block).
//
// Ports
//   clk, reset                      clock; synchronous active-high reset
//   ds_issue, ds_gr_we, ds_dest     decode issue event and its destination
//   ds_rj/rk/rd, ds_use_rj/rk/rd    sources of the instruction in decode
//   ws_retire, ws_gr_we, ws_dest    writeback retire event and destination
//   flush                           discard all pending writers
//   raw_stall                       combinational read-after-write hold
//   issue_block                     combinational hold: dest counter full
//   busy_vec                        registered per-register busy flags
//   stall_cycles                    registered count of held cycles
// ---------------------------------------------------------------------------
module rf_scoreboard #(
    parameter int NREG = 32,
    parameter int CW   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ds_issue,
    input  logic            ds_gr_we,
    input  logic [4:0]      ds_dest,
    input  logic [4:0]      ds_rj,
    input  logic [4:0]      ds_rk,
    input  logic [4:0]      ds_rd,
    input  logic            ds_use_rj,
    input  logic            ds_use_rk,
    input  logic            ds_use_rd,
    input  logic            ws_retire,
    input  logic            ws_gr_we,
    input  logic [4:0]      ws_dest,
    input  logic            flush,
    output logic            raw_stall,
    output logic            issue_block,
    output logic [NREG-1:0] busy_vec,
    output logic [31:0]     stall_cycles
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic            inc_s;
    logic            dec_s;
    logic [NREG-1:0] inc_vec_s;
    logic [NREG-1:0] dec_vec_s;
    logic [CW-1:0]   count_r      [1:NREG-1];
    logic [CW-1:0]   count_next_s [1:NREG-1];
    logic [CW-1:0]   cnt_view_s   [0:NREG-1];
    logic [NREG-1:0] busy_next_s;
    logic            raw_stall_s;
    logic            issue_block_s;
    logic [NREG-1:0] busy_vec_r;
    logic [31:0]     stall_cycles_r;

    // r0 is never tracked, so neither event is allowed to touch it.
    assign inc_s = ds_issue && ds_gr_we && (ds_dest != 5'd0);
    assign dec_s = ws_retire && ws_gr_we && (ws_dest != 5'd0);

    // One-hot decode of the increment and decrement targets.
    always_comb begin
        inc_vec_s = {NREG{1'b0}};
        dec_vec_s = {NREG{1'b0}};
        if (inc_s) begin
            inc_vec_s[ds_dest] = 1'b1;
        end else begin
            inc_vec_s = {NREG{1'b0}};
        end
        if (dec_s) begin
            dec_vec_s[ws_dest] = 1'b1;
        end else begin
            dec_vec_s = {NREG{1'b0}};
        end
    end

    // Read view of the counters with a hard-wired zero entry for r0.
    always_comb begin
        cnt_view_s[0] = CNT_ZERO;
        for (int i = 1; i < NREG; i++) begin
            cnt_view_s[i] = count_r[i];
        end
    end

    // Next counter values: flush wins, inc+dec cancel, otherwise saturate
    // at both ends so protocol errors never wrap a counter.
    always_comb begin
        busy_next_s = {NREG{1'b0}};
        for (int i = 1; i < NREG; i++) begin
            count_next_s[i] = count_r[i];
            if (flush) begin
                count_next_s[i] = CNT_ZERO;
            end else if (inc_vec_s[i] && dec_vec_s[i]) begin
                count_next_s[i] = count_r[i];
            end else if (inc_vec_s[i]) begin
                if (count_r[i] != CNT_MAX) begin
                    count_next_s[i] = count_r[i] + CNT_ONE;
                end else begin
                    count_next_s[i] = CNT_MAX;
                end
            end else if (dec_vec_s[i]) begin
                if (count_r[i] != CNT_ZERO) begin
                    count_next_s[i] = count_r[i] - CNT_ONE;
                end else begin
                    count_next_s[i] = CNT_ZERO;
                end
            end else begin
                count_next_s[i] = count_r[i];
            end
            busy_next_s[i] = (count_next_s[i] != CNT_ZERO);
        end
    end

    // Hazard outputs read only the registered counters. A writer retiring
    // this cycle still counts as busy: its value reaches the RF next cycle.
    always_comb begin
        raw_stall_s = 1'b0;
        issue_block_s = 1'b0;
        if ((ds_use_rj && (cnt_view_s[ds_rj] != CNT_ZERO)) ||
            (ds_use_rk && (cnt_view_s[ds_rk] != CNT_ZERO)) ||
            (ds_use_rd && (cnt_view_s[ds_rd] != CNT_ZERO))) begin
            raw_stall_s = 1'b1;
        end else begin
            raw_stall_s = 1'b0;
        end
        if (ds_gr_we && (ds_dest != 5'd0) && (cnt_view_s[ds_dest] == CNT_MAX)) begin
            issue_block_s = 1'b1;
        end else begin
            issue_block_s = 1'b0;
        end
    end

    // Counter state, busy flags and the stall performance counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) begin
                count_r[i] <= CNT_ZERO;
            end
            busy_vec_r     <= {NREG{1'b0}};
            stall_cycles_r <= 32'd0;
        end else begin
            count_r    <= count_next_s;
            busy_vec_r <= busy_next_s;
            if ((raw_stall_s || issue_block_s) && !flush) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end
        end
    end

    assign raw_stall    = raw_stall_s;
    assign issue_block  = issue_block_s;
    assign busy_vec     = busy_vec_r;
    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_rf_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_rf_scoreboard
//
// Directed bench for rf_scoreboard. A table of one-cycle records gives the
// inputs, the expected combinational hazard outputs during that cycle, and
// the expected registered outputs after the clock edge. A hand-written
// sequence then exercises the RAW release timing with a bounded wait.
// ---------------------------------------------------------------------------
module tb_rf_scoreboard;

    logic        clk;
    logic        reset;
    logic        ds_issue;
    logic        ds_gr_we;
    logic [4:0]  ds_dest;
    logic [4:0]  ds_rj;
    logic [4:0]  ds_rk;
    logic [4:0]  ds_rd;
    logic        ds_use_rj;
    logic        ds_use_rk;
    logic        ds_use_rd;
    logic        ws_retire;
    logic        ws_gr_we;
    logic [4:0]  ws_dest;
    logic        flush;
    logic        raw_stall;
    logic        issue_block;
    logic [31:0] busy_vec;
    logic [31:0] stall_cycles;

    rf_scoreboard #(.NREG(32), .CW(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .ds_issue     (ds_issue),
        .ds_gr_we     (ds_gr_we),
        .ds_dest      (ds_dest),
        .ds_rj        (ds_rj),
        .ds_rk        (ds_rk),
        .ds_rd        (ds_rd),
        .ds_use_rj    (ds_use_rj),
        .ds_use_rk    (ds_use_rk),
        .ds_use_rd    (ds_use_rd),
        .ws_retire    (ws_retire),
        .ws_gr_we     (ws_gr_we),
        .ws_dest      (ws_dest),
        .flush        (flush),
        .raw_stall    (raw_stall),
        .issue_block  (issue_block),
        .busy_vec     (busy_vec),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iss;
        logic        gwe;
        logic [4:0]  dest;
        logic        ret;
        logic        wwe;
        logic [4:0]  wdest;
        logic [4:0]  rj;
        logic        urj;
        logic [4:0]  rk;
        logic        urk;
        logic [4:0]  rd;
        logic        urd;
        logic        e_raw;
        logic        e_blk;
        logic [31:0] e_busy;
        logic [31:0] e_sc;
    } vec_t;

    localparam int NVEC = 32;
    vec_t vecs [NVEC];

    int n_vec;
    int n_cmp;
    int n_fail;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        reset     = 1'b0;
        flush     = 1'b0;
        ds_issue  = 1'b0;
        ds_gr_we  = 1'b0;
        ds_dest   = 5'd0;
        ws_retire = 1'b0;
        ws_gr_we  = 1'b0;
        ws_dest   = 5'd0;
        ds_rj     = 5'd0;
        ds_use_rj = 1'b0;
        ds_rk     = 5'd0;
        ds_use_rk = 1'b0;
        ds_rd     = 5'd0;
        ds_use_rd = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_cmp  = 0;
        n_fail = 0;

        //          rst   fl    iss   gwe   dest   ret   wwe   wdest  rj    urj   rk     urk   rd    urd   raw   blk   busy          sc
        // Reset state query.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  5'd5, 1'b1, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'd0};
        // Producer r7 at cycle 0, consumer stalls cycles 1-3, retire at 3, issue at 4.
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0080, 32'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  5'd7, 1'b1, 5'd0,  1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  5'd7, 1'b1, 5'd0,  1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'd2};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd7,  5'd7, 1'b1, 5'd0,  1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'd3};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  5'd7, 1'b1, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'd3};
        // Same-cycle issue and retire to r9 while count[9]=1.
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'd3};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd9,  1'b1, 1'b1, 5'd9,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'd3};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd9,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'd3};
        // Saturation of r4 at 3, forced issue, then retires.
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd4,  1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'd3};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd4,  1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'd3};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd4,  1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'd3};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd4,  1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'd4};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd4,  1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'd5};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd4,  1'b1, 1'b1, 5'd4,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'd6};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd4,  1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'd6};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd4,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'd6};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd4,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'd6};
        // Retire to an idle register must not wrap: one issue then leaves count 1.
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd4,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'd6};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd4,  1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'd6};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd4,  1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'd6};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd4,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'd6};
        // r0 as destination and source.
        vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 5'd0,  5'd0, 1'b1, 5'd0,  1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'd6};
        // r3 and r12 pending, rk/rd sources stall, flush with issue to r3.
        vecs[23] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd3,  1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'd6};
        vecs[24] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_1008, 32'd6};
        vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 5'd12, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 32'h0000_1008, 32'd7};
        vecs[26] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 32'h0000_1008, 32'd8};
        vecs[27] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd3,  1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 5'd12, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'd8};
        vecs[28] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 5'd12, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'd8};
        // Mid-sequence reset.
        vecs[29] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'd8};
        vecs[30] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  5'd5, 1'b1, 5'd0,  1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'd0};
        vecs[31] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  5'd5, 1'b1, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'd0};

        drive_idle();
        reset = 1'b1;
        tick();
        tick();

        for (int i = 0; i < NVEC; i++) begin
            reset     = vecs[i].rst;
            flush     = vecs[i].fl;
            ds_issue  = vecs[i].iss;
            ds_gr_we  = vecs[i].gwe;
            ds_dest   = vecs[i].dest;
            ws_retire = vecs[i].ret;
            ws_gr_we  = vecs[i].wwe;
            ws_dest   = vecs[i].wdest;
            ds_rj     = vecs[i].rj;
            ds_use_rj = vecs[i].urj;
            ds_rk     = vecs[i].rk;
            ds_use_rk = vecs[i].urk;
            ds_rd     = vecs[i].rd;
            ds_use_rd = vecs[i].urd;
            #2;
            check("raw_stall", i, {31'd0, raw_stall}, {31'd0, vecs[i].e_raw});
            check("issue_block", i, {31'd0, issue_block}, {31'd0, vecs[i].e_blk});
            tick();
            check("busy_vec", i, busy_vec, vecs[i].e_busy);
            check("stall_cycles", i, stall_cycles, vecs[i].e_sc);
            n_vec++;
        end

        // Hand-written RAW release sequence through rk on r20, with a bounded
        // wait for the stall to drop once the producer retires.
        begin
            int waited;
            drive_idle();
            ds_issue = 1'b1;
            ds_gr_we = 1'b1;
            ds_dest  = 5'd20;
            tick();
            n_vec++;
            drive_idle();
            ds_rk     = 5'd20;
            ds_use_rk = 1'b1;
            for (int c = 1; c <= 3; c++) begin
                if (c == 3) begin
                    ws_retire = 1'b1;
                    ws_gr_we  = 1'b1;
                    ws_dest   = 5'd20;
                end
                #2;
                check("seq_raw_held", 100 + c, {31'd0, raw_stall}, 32'd1);
                tick();
                n_vec++;
            end
            ws_retire = 1'b0;
            ws_gr_we  = 1'b0;
            ws_dest   = 5'd0;
            #2;
            waited = 0;
            while (raw_stall === 1'b1 && waited < 8) begin
                tick();
                waited++;
            end
            check("seq_release_wait", 104, waited, 32'd0);
            check("seq_busy_vec", 105, busy_vec, 32'h0000_0000);
            check("seq_stall_cycles", 106, stall_cycles, 32'd3);
            n_vec++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Register-file write scoreboard for the five-stage in-order LoongArch pipeline. It tracks the number of in-flight writers for each architectural GPR between decode issue and writeback retire. It raises a read-after-write stall to decode when a source register still has a pending writer. It owns the scheduling decision that the RF write port's retire stream (ws_to_rf_bus: we, dest, data) implies.

## Interface
- Parameters:
- NREG, 32, number of architectural registers; r0 is never tracked.
- CW, 2, per-register pending-count width; maximum count is 2^CW-1.
- Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ds_issue  in  1  decode hands an instruction to execute this cycle (ds_valid && ds_ready_go && es_allowin)
- ds_gr_we  in  1  the issuing instruction writes a GPR
- ds_dest  in  5  destination of the issuing instruction
- ds_rj, ds_rk, ds_rd  in  5 each  source register numbers of the instruction currently in decode
- ds_use_rj, ds_use_rk, ds_use_rd  in  1 each  the corresponding source is actually read
- ws_retire  in  1  writeback commits this cycle (ws_valid)
- ws_gr_we  in  1  the retiring instruction writes a GPR
- ws_dest  in  5  destination of the retiring instruction
- flush  in  1  whole pipeline beyond decode discarded; clears all pending state
- raw_stall  out  1  combinational; decode must hold (ds_ready_go low)
- issue_block  out  1  combinational; ds_dest count is saturated, so decode must hold
- busy_vec  out  NREG  registered; bit i = count[i] != 0; bit 0 always 0
- stall_cycles  out  32  registered performance counter of cycles with raw_stall || issue_block

## Operation
- State: count[1..NREG-1], CW bits each. No count[0] exists; reads of r0 return 0.
- inc = ds_issue && ds_gr_we && ds_dest != 0.
- dec = ws_retire && ws_gr_we && ws_dest != 0.
- Per register i, each clock:
  - If flush: 0.
  - Else if inc to i and dec to i in the same cycle: unchanged (net zero).
  - Else if inc to i: +1.
  - Else if dec to i: -1.
- raw_stall = (ds_use_rj && busy(rj)) || (ds_use_rk && busy(rk)) || (ds_use_rd && busy(rd)).
  - busy(x) uses the current registered count, excluding a same-cycle dec to x. A retiring value becomes visible through the RF the next cycle, so no bypass is allowed.
- issue_block = ds_gr_we && ds_dest != 0 && count[ds_dest] == 2^CW-1.
- Decode must not assert ds_issue while raw_stall or issue_block is high.
  - If ds_issue arrives with issue_block high (protocol error), the count saturates at max and does not wrap.
- A dec to a register whose count is 0 (protocol error) leaves it at 0 and does not wrap.
- flush takes priority over a simultaneous inc or dec.
- stall_cycles increments by 1 per cycle while (raw_stall || issue_block) && !flush. It wraps at 2^32 and is cleared only by reset.

## Timing
- Reset: all counts 0, busy_vec = 0, stall_cycles = 0. raw_stall and issue_block are 0 for any input once reset has been applied.
- inc at edge N: busy_vec bit set and raw_stall visible from cycle N+1.
- dec at edge N: count drops after edge N. The stall releases in cycle N+1, the same cycle the RF holds the new value.
- Minimum RAW stall for back-to-back dependent instructions, issue at cycle 0 and writeback at cycle 3: stall is asserted in cycles 1-3, and the consumer issues in cycle 4.
- flush at edge N: all counts 0 from cycle N+1, regardless of issue or retire in cycle N.
- Reset asserted mid-operation behaves exactly like power-on reset on the next edge.
- No combinational path from ds_issue or ws_retire to raw_stall. raw_stall depends only on registered counts and the ds_* source fields.

## Test plan
- Reset, then query rj=5 with use_rj=1: raw_stall=0, busy_vec=0, stall_cycles=0.
- Issue dest=7 at cycle 0, then hold a consumer with rj=7 in decode; retire dest=7 at cycle 3: raw_stall is 1 in cycles 1-3 and 0 in cycle 4; stall_cycles=3.
- Issue dest=9 and retire dest=9 in the same cycle while count[9]=1: count stays 1 and busy_vec[9] stays 1.
- Issue dest=4 three times with no retire: issue_block=1 on the fourth attempt and count[4]=3. A forced fourth ds_issue leaves count at 3. A retire drops it to 2.
- Issue dest=0 and source rj=0: busy_vec[0]=0, raw_stall=0, no count change.
- Set counts for r3 and r12, then assert flush with a simultaneous issue to r3: busy_vec=0 next cycle. Asserting reset mid-sequence yields the reset values on the next cycle.
